cic_decimator: RTL

CIC_DECIMATOR -- requirements
Module: cic_decimator

---
 rtl/cic_pkg.sv | 23 ++
 rtl/cic_comb_stage.sv | 47 ++++
 rtl/cic_decimator.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/cic_pkg.sv
// cic_pkg
// Shared constants and sizing helpers for the sinc^3 decimation chain.
// Downstream filter stages import this package so that they size their
// datapaths from the same decimation ratio as the CIC front end.
//   CIC_ORDER      : number of integrator/comb pairs (3).
//   cic_acc_w()    : accumulator width for a given log2 decimation ratio.
//   cic_out_shift(): right shift that maps full scale onto an OUT_W word.
package cic_pkg;

  localparam int CIC_ORDER = 3;

  // Full-scale gain is R^ORDER = 2^(ORDER*log2R); one extra bit keeps the
  // two's-complement comb differences unambiguous.
  function automatic int cic_acc_w(input int decim_log2);
    return (CIC_ORDER * decim_log2) + 32'sd1;
  endfunction

  // Drop the low bits so that the top OUT_W+1 bits of the accumulator remain.
  function automatic int cic_out_shift(input int decim_log2, input int out_w);
    return cic_acc_w(decim_log2) - 32'sd1 - out_w;
  endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// cic_comb_stage
// One comb (differentiator) section: y = x - x_prev, where x_prev is the
// input captured at the previous enabled edge.
// Ports:
//   clk   : clock, rising edge
//   rstN  : asynchronous active-low reset (clears the delay register)
//   en_i  : capture x_i into the delay register on this edge
//   x_i   : stage input (W bits, two's complement, wrapping)
//   y_o   : combinational difference x_i - x_prev
module cic_comb_stage
  import cic_pkg::*;
#(
  parameter int W = 19
) (
  input  logic         clk,
  input  logic         rstN,
  input  logic         en_i,
  input  logic [W-1:0] x_i,
  output logic [W-1:0] y_o
);

  logic [W-1:0] prev_q;
  logic [W-1:0] prev_d;

  // Next value of the delay register: follows the input only when enabled.
  always_comb begin
    prev_d = prev_q;
    if (en_i) begin
      prev_d = x_i;
    end else begin
      prev_d = prev_q;
    end
  end

  // Delay register.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      prev_q <= '0;
    end else begin
      prev_q <= prev_d;
    end
  end

  // Modular subtraction; wrap is the intended CIC arithmetic.
  assign y_o = x_i - prev_q;

endmodule

// File: rtl/cic_decimator.sv
// cic_decimator
// Third-order CIC (sinc^3) decimator for a 1-bit delta-sigma stream,
// decimation ratio R = 2^DECIM_LOG2, differential delay 1, with a
// valid/ready output register and a sticky overrun flag.
// Optional build macro: CIC_SAT_EN -- when defined, a scaled result that
// does not fit OUT_W bits saturates to all-ones; otherwise it truncates.
// Ports:
//   clk        : modulator-rate clock, rising edge
//   rstN       : asynchronous active-low reset
//   dsIn       : bitstream input, 1 = +1, 0 = 0
//   dataOut    : decimated unsigned sample (OUT_W bits)
//   outValid   : dataOut holds an unconsumed sample
//   outReady   : consumer accepts dataOut when outValid && outReady
//   overrun    : sticky, a sample was overwritten before acceptance
//   clrOverrun : synchronous clear of overrun (a coincident set wins)
module cic_decimator
  import cic_pkg::*;
#(
  parameter int DECIM_LOG2 = 6,
  parameter int OUT_W      = 16
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             dsIn,
  output logic [OUT_W-1:0] dataOut,
  output logic             outValid,
  input  logic             outReady,
  output logic             overrun,
  input  logic             clrOverrun
);

  localparam int ACC_W = cic_acc_w(DECIM_LOG2);
  localparam int SHIFT = cic_out_shift(DECIM_LOG2, OUT_W);

  logic [ACC_W-1:0]      int1_q, int2_q, int3_q;
  logic [ACC_W-1:0]      int1_d, int2_d, int3_d;
  logic [DECIM_LOG2-1:0] cnt_q, cnt_d;
  logic [1:0]            warm_q, warm_d;
  logic [OUT_W-1:0]      data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  ovr_q, ovr_d;

  logic                  strobe_s;
  logic                  set_ovr_s;
  logic [ACC_W-1:0]      comb1_s, comb2_s, comb3_s;
  logic [OUT_W:0]        shifted_s;
  logic [OUT_W-1:0]      sample_s;
  logic                  unused_s;

  assign strobe_s = (cnt_q == {DECIM_LOG2{1'b1}});

  // Integrator cascade and decimation counter; each integrator sees the
  // already-updated value of the one before it, so int3_d includes this
  // cycle's input bit.
  always_comb begin
    int1_d = int1_q + {{(ACC_W-1){1'b0}}, dsIn};
    int2_d = int2_q + int1_d;
    int3_d = int3_q + int2_d;
    cnt_d  = cnt_q + {{(DECIM_LOG2-1){1'b0}}, 1'b1};
  end

  cic_comb_stage #(.W(ACC_W)) u_comb0 (
    .clk  (clk),
    .rstN (rstN),
    .en_i (strobe_s),
    .x_i  (int3_d),
    .y_o  (comb1_s)
  );

  cic_comb_stage #(.W(ACC_W)) u_comb1 (
    .clk  (clk),
    .rstN (rstN),
    .en_i (strobe_s),
    .x_i  (comb1_s),
    .y_o  (comb2_s)
  );

  cic_comb_stage #(.W(ACC_W)) u_comb2 (
    .clk  (clk),
    .rstN (rstN),
    .en_i (strobe_s),
    .x_i  (comb2_s),
    .y_o  (comb3_s)
  );

  // Keep OUT_W+1 bits so that full scale (2^(ACC_W-1)) is still visible
  // as the bit just above the output word.
  assign shifted_s = comb3_s[ACC_W-1:SHIFT];

`ifdef CIC_SAT_EN
  assign sample_s = shifted_s[OUT_W] ? {OUT_W{1'b1}} : shifted_s[OUT_W-1:0];
`else
  assign sample_s = shifted_s[OUT_W-1:0];
`endif

  // Low-order comb bits are discarded by the scaling.
  assign unused_s = ^{comb3_s, shifted_s};

  // Warm-up, output register and handshake.
  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    warm_d    = warm_q;
    set_ovr_s = 1'b0;
    if (strobe_s) begin
      if (warm_q != 2'd2) begin
        // Comb state primes during the first strobes; nothing is presented.
        warm_d = warm_q + 2'd1;
      end else begin
        data_d    = sample_s;
        valid_d   = 1'b1;
        set_ovr_s = valid_q && !outReady;
      end
    end else if (valid_q && outReady) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end

    ovr_d = ovr_q;
    if (set_ovr_s) begin
      ovr_d = 1'b1;
    end else if (clrOverrun) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      int1_q  <= '0;
      int2_q  <= '0;
      int3_q  <= '0;
      cnt_q   <= '0;
      warm_q  <= 2'd0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      int1_q  <= int1_d;
      int2_q  <= int2_d;
      int3_q  <= int3_d;
      cnt_q   <= cnt_d;
      warm_q  <= warm_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign dataOut  = data_q;
  assign outValid = valid_q;
  assign overrun  = ovr_q;

endmodule
